// File: rtl/pipelined_mixed_adder.sv
// Segmented ripple-carry adder: one pipeline stage per SEG-bit slice,
// valid/ready flow control with whole-pipeline stall, bitwise side results.
module pipelined_mixed_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             C_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S_out,
  output logic [WIDTH-1:0] AND_out,
  output logic [WIDTH-1:0] OR_out,
  output logic [WIDTH-1:0] XOR_out,
  output logic             C_out,
  output logic             V_out,
  output logic             Z_out
);

  localparam int NSEG = WIDTH / SEG;
  localparam int L    = NSEG - 1;

  logic [NSEG-1:0]            vld_q;
  logic [NSEG-1:0]            sub_q;
  logic [NSEG-1:0]            c_q;
  logic [NSEG-1:0][WIDTH-1:0] a_q;
  logic [NSEG-1:0][WIDTH-1:0] bo_q;
  logic [NSEG-1:0][WIDTH-1:0] s_q;
  logic                       z_q;

  logic [NSEG-1:0]            sv;
  logic [NSEG-1:0]            ssub;
  logic [NSEG-1:0]            sc;
  logic [NSEG-1:0][WIDTH-1:0] sa;
  logic [NSEG-1:0][WIDTH-1:0] sbo;
  logic [NSEG-1:0][WIDTH-1:0] ss;
  logic [NSEG-1:0][WIDTH-1:0] s_d;
  logic [NSEG-1:0]            c_d;
  logic [SEG-1:0]             asg;
  logic [SEG-1:0]             bsg;
  logic [SEG:0]               seg;
  logic                       advance;

  assign advance  = !(vld_q[L] && !out_ready);
  assign in_ready = advance;

  // Stage k sees stage k-1 registers; stage 0 sees the ports.
  // The invert for subtraction is applied per segment from the
  // carried sub bit, so only the original B travels down the pipe.
  always_comb begin
    sv[0]   = in_valid;
    ssub[0] = sub;
    sc[0]   = sub ? 1'b1 : C_in;
    sa[0]   = A_in;
    sbo[0]  = B_in;
    ss[0]   = '0;
    for (int k = 1; k < NSEG; k++) begin
      sv[k]   = vld_q[k-1];
      ssub[k] = sub_q[k-1];
      sc[k]   = c_q[k-1];
      sa[k]   = a_q[k-1];
      sbo[k]  = bo_q[k-1];
      ss[k]   = s_q[k-1];
    end
    asg = '0;
    bsg = '0;
    seg = '0;
    s_d = ss;
    c_d = '0;
    for (int k = 0; k < NSEG; k++) begin
      asg = sa[k][k*SEG +: SEG];
      bsg = sbo[k][k*SEG +: SEG];
      if (ssub[k]) bsg = ~bsg;
      seg = {1'b0, asg} + {1'b0, bsg}
          + {{SEG{1'b0}}, sc[k]};
      s_d[k][k*SEG +: SEG] = seg[SEG-1:0];
      c_d[k] = seg[SEG];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      sub_q <= '0;
      c_q   <= '0;
      a_q   <= '0;
      bo_q  <= '0;
      s_q   <= '0;
      z_q   <= 1'b0;
    end else if (advance) begin
      vld_q <= sv;
      sub_q <= ssub;
      c_q   <= c_d;
      a_q   <= sa;
      bo_q  <= sbo;
      s_q   <= s_d;
      z_q   <= (s_d[L] == '0);
    end
  end

  assign out_valid = vld_q[L];
  assign S_out     = s_q[L];
  assign C_out     = c_q[L];
  assign Z_out     = z_q;
  assign AND_out   = a_q[L] & bo_q[L];
  assign OR_out    = a_q[L] | bo_q[L];
  assign XOR_out   = a_q[L] ^ bo_q[L];

  // Same-sign operands producing an opposite-sign sum.
  assign V_out =
    (a_q[L][WIDTH-1] == (bo_q[L][WIDTH-1] ^ sub_q[L]))
    && (s_q[L][WIDTH-1] != a_q[L][WIDTH-1]);

endmodule
